pmcc_code_loader: RTL and testbench



---
 rtl/pmcc_code_loader_pkg.sv | 18 +
 rtl/ibex_data_bus.sv | 24 ++
 rtl/pmcc_code_loader.sv | 165 ++++++++++++++++
 tb/tb_pmcc_code_loader.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmcc_code_loader_pkg.sv
// Shared types and constants for the PMC code loader.
// The RD/WAIT_R states are only reached when PMCC_CODE_LOADER_VERIFY_EN is defined.
package pmcc_code_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WRITE  = 3'd2,
        ST_WAIT_W = 3'd3,
        ST_RD     = 3'd4,
        ST_WAIT_R = 3'd5,
        ST_DONE   = 3'd6
    } pmcc_loader_state_t;

    localparam logic [31:0] PMCC_WORD_BYTES = 32'd4;
    localparam logic [3:0]  PMCC_FULL_BE    = 4'hF;

endpackage

// File: rtl/ibex_data_bus.sv
// Ibex-style data bus: req/gnt address phase, rvalid response phase.
interface ibex_data_bus;
    logic        req;
    logic        gnt;
    logic        rvalid;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [6:0]  wdata_intg;
    logic [31:0] rdata;
    logic [6:0]  rdata_intg;
    logic        err;

    modport master (
        output req, we, be, addr, wdata, wdata_intg,
        input  gnt, rvalid, rdata, rdata_intg, err
    );

    modport slave (
        input  req, we, be, addr, wdata, wdata_intg,
        output gnt, rvalid, rdata, rdata_intg, err
    );
endinterface

// File: rtl/pmcc_code_loader.sv
// Bus initiator that copies a valid/ready word stream into consecutive code RAM words.
// Define PMCC_CODE_LOADER_VERIFY_EN to read back and compare each word after writing it.
module pmcc_code_loader
    import pmcc_code_loader_pkg::*;
#(
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_count,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] words_written,
    ibex_data_bus.master     data_bus
);

    pmcc_loader_state_t r_state;
    logic [31:0]        r_addr;      // address of the next word to write
    logic [31:0]        r_bus_addr;  // address currently presented on the bus
    logic [31:0]        r_word;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_words;
    logic               r_in_ready;
    logic               r_busy;
    logic               r_done;
    logic               r_error;
    logic               r_req;
    logic               r_we;
    logic [3:0]         r_be;

    logic [CNT_W-1:0]   w_words_inc;
    logic               w_last_write;

    assign w_words_inc  = r_words + 1'b1;
    assign w_last_write = (w_words_inc == r_count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_bus_addr <= '0;
            r_word     <= '0;
            r_count    <= '0;
            r_words    <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_be       <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_addr  <= base_addr & ~32'd3;
                        r_count <= word_count;
                        r_words <= '0;
                        r_error <= 1'b0;
                        r_busy  <= 1'b1;
                        if (word_count == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= ST_FETCH;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (in_valid && r_in_ready) begin
                        r_word     <= in_data;
                        r_in_ready <= 1'b0;
                        r_bus_addr <= r_addr;
                        r_req      <= 1'b1;
                        r_we       <= 1'b1;
                        r_be       <= PMCC_FULL_BE;
                        r_state    <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (data_bus.gnt) begin
                        r_req   <= 1'b0;
                        r_state <= ST_WAIT_W;
                    end
                end
                ST_WAIT_W: begin
                    if (data_bus.rvalid) begin
                        if (data_bus.err) begin
                            r_error <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_words <= w_words_inc;
                            r_addr  <= r_addr + PMCC_WORD_BYTES;
`ifdef PMCC_CODE_LOADER_VERIFY_EN
                            // r_bus_addr still holds the word just written
                            r_req   <= 1'b1;
                            r_we    <= 1'b0;
                            r_state <= ST_RD;
`else
                            if (w_last_write) begin
                                r_done  <= 1'b1;
                                r_state <= ST_DONE;
                            end else begin
                                r_in_ready <= 1'b1;
                                r_state    <= ST_FETCH;
                            end
`endif
                        end
                    end
                end
`ifdef PMCC_CODE_LOADER_VERIFY_EN
                ST_RD: begin
                    if (data_bus.gnt) begin
                        r_req   <= 1'b0;
                        r_state <= ST_WAIT_R;
                    end
                end
                ST_WAIT_R: begin
                    if (data_bus.rvalid) begin
                        if (data_bus.err || (data_bus.rdata != r_word)) begin
                            r_error <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else if (r_words == r_count) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_in_ready <= 1'b1;
                            r_state    <= ST_FETCH;
                        end
                    end
                end
`endif
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready      = r_in_ready;
    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;
    assign words_written = r_words;

    assign data_bus.req        = r_req;
    assign data_bus.we         = r_we;
    assign data_bus.be         = r_be;
    assign data_bus.addr       = r_bus_addr;
    assign data_bus.wdata      = r_word;
    assign data_bus.wdata_intg = '0;

endmodule

// File: tb/tb_pmcc_code_loader.sv
// Self-checking bench for pmcc_code_loader: RAM slave with random gnt/rvalid delays,
// random stream source, and a transaction-level model of the expected bus traffic.
`timescale 1ns/1ps
module tb_pmcc_code_loader;
    localparam int CNT_W = 9;
`ifdef PMCC_CODE_LOADER_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [31:0]      base_addr = '0;
    logic [CNT_W-1:0] word_count = '0;
    logic [31:0]      in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready, busy, done, error;
    logic [CNT_W-1:0] words_written;

    ibex_data_bus bus ();

    pmcc_code_loader #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .busy(busy), .done(done), .error(error),
        .words_written(words_written), .data_bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    int checks = 0;
    int errors = 0;

    txn_t        exp_q[$];
    logic [31:0] stream[$];
    logic [31:0] mem [logic [31:0]];
    int  m_words;
    bit  m_error;
    int  gnt_fixed = -1, gnt_max = 0, rsp_max = 0, err_at = -1, corrupt_at = -1;
    bit  valid_rand = 1'b0;
    int  src_idx = 0, wr_idx = 0, rd_idx = 0, done_cnt = 0, req_cycles = 0;
    bit  src_fire_p = 1'b0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // Expected traffic: one write per word, plus a read-back when verify is built in;
    // the load stops at the first bus error or read-back mismatch.
    task automatic model_load(input logic [31:0] base, input int n);
        logic [31:0] a;
        txn_t t;
        a = base & 32'hFFFF_FFFC;
        exp_q.delete();
        m_words = n;
        m_error = 1'b0;
        for (int i = 0; i < n; i++) begin
            t.we = 1'b1; t.addr = a; t.data = stream[i];
            exp_q.push_back(t);
            if (i == err_at) begin
                m_words = i; m_error = 1'b1; return;
            end
            if (VERIFY) begin
                t.we = 1'b0;
                exp_q.push_back(t);
                if (i == corrupt_at) begin
                    m_words = i + 1; m_error = 1'b1; return;
                end
            end
            a = a + 32'd4;
        end
    endtask

    // Stream source: offers the next word (random valid gaps), junk once the load's words run out.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                in_valid = 1'b0;
                src_fire_p = 1'b0;
            end else begin
                if (src_fire_p) src_idx++;
                if (src_idx < stream.size()) begin
                    in_data  = stream[src_idx];
                    in_valid = valid_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
                end else begin
                    in_data  = 32'hBAD0_0000 | 32'(src_idx);
                    in_valid = 1'b1;
                end
                src_fire_p = in_valid && in_ready;
            end
        end
    end

    // RAM slave and the single compare process for bus traffic and status handshakes.
    initial begin
        logic        holding, acc_p, pend, rsp_err, prev_done;
        logic        h_we;
        logic [3:0]  h_be;
        logic [31:0] h_addr, h_wdata, rsp_data;
        int          gwait, rwait;
        txn_t        e;
        holding = 0; acc_p = 0; pend = 0; rsp_err = 0; prev_done = 0;
        h_we = 0; h_be = 0; h_addr = 0; h_wdata = 0; rsp_data = 0; gwait = 0; rwait = 0;
        bus.gnt = 0; bus.rvalid = 0; bus.err = 0; bus.rdata = 0; bus.rdata_intg = 0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                bus.gnt = 0; bus.rvalid = 0; bus.err = 0;
                holding = 0; acc_p = 0; pend = 0; prev_done = 0;
            end else begin
                bus.rvalid = 0; bus.err = 0;
                if (acc_p) begin
                    check("txn_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("txn_we", 64'(h_we), 64'(e.we));
                        check("txn_addr", 64'(h_addr), 64'(e.addr));
                        if (e.we) begin
                            check("txn_be", 64'(h_be), 64'hF);
                            check("txn_wdata", 64'(h_wdata), 64'(e.data));
                        end
                    end
                    if (h_we) begin
                        rsp_err = (wr_idx == err_at);
                        if (!rsp_err) mem[h_addr] = h_wdata;
                        wr_idx++;
                    end else begin
                        rsp_err  = 1'b0;
                        rsp_data = mem.exists(h_addr) ? mem[h_addr] : 32'd0;
                        if (rd_idx == corrupt_at) rsp_data = rsp_data ^ 32'h1;
                        rd_idx++;
                    end
                    pend  = 1'b1;
                    rwait = $urandom_range(0, rsp_max);
                end
                if (pend) begin
                    if (rwait == 0) begin
                        bus.rvalid = 1'b1; bus.err = rsp_err; bus.rdata = rsp_data; pend = 1'b0;
                    end else begin
                        rwait--;
                    end
                end
                bus.gnt = 1'b0;
                acc_p   = 1'b0;
                if (bus.req) begin
                    req_cycles++;
                    check("single_outstanding", 64'(pend || bus.rvalid), 64'd0);
                    if (!holding) begin
                        holding = 1'b1;
                        h_we = bus.we; h_be = bus.be; h_addr = bus.addr; h_wdata = bus.wdata;
                        gwait = (gnt_fixed >= 0) ? gnt_fixed : $urandom_range(0, gnt_max);
                    end else begin
                        check("req_stable_addr_data", {bus.addr, bus.wdata}, {h_addr, h_wdata});
                        check("req_stable_we_be", 64'({bus.we, bus.be}), 64'({h_we, h_be}));
                    end
                    if (gwait == 0) begin
                        bus.gnt = 1'b1; acc_p = 1'b1; holding = 1'b0;
                    end else begin
                        gwait--;
                    end
                end else begin
                    check("req_held_until_gnt", 64'(holding), 64'd0);
                    holding = 1'b0;
                end
                if (prev_done) check("busy_after_done", 64'(busy), 64'd0);
                if (done) begin
                    done_cnt++;
                    check("busy_with_done", 64'(busy), 64'd1);
                end
                check("ready_only_busy", 64'(in_ready && !busy), 64'd0);
                prev_done = done;
            end
        end
    end

    task automatic fill_random(input int n);
        stream.delete();
        for (int i = 0; i < n; i++) stream.push_back($urandom);
    endtask

    task automatic run_load(input string name, input logic [31:0] base, input int n,
                            input int g_fixed, input int g_max, input int r_max,
                            input int e_at, input int c_at, input bit vrand, input bit poke,
                            output int lat);
        @(negedge clk);
        gnt_fixed = g_fixed; gnt_max = g_max; rsp_max = r_max;
        err_at = e_at; corrupt_at = c_at; valid_rand = vrand;
        model_load(base, n);
        src_idx = 0; wr_idx = 0; rd_idx = 0; done_cnt = 0;
        start = 1'b1; base_addr = base; word_count = CNT_W'(n);
        @(posedge clk); #2;
        start = 1'b0; base_addr = $urandom; word_count = CNT_W'($urandom);
        lat = 1;
        while (!done && lat < 3000) begin
            if (poke && lat == 4) begin
                start = 1'b1; word_count = '0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #2;
            lat++;
        end
        start = 1'b0;
        check({name, "_done_seen"}, 64'(done), 64'd1);
        check({name, "_error"}, 64'(error), 64'(m_error));
        check({name, "_words"}, 64'(words_written), 64'(m_words));
        repeat (3) @(posedge clk);
        #2;
        check({name, "_all_txns"}, 64'(exp_q.size()), 64'd0);
        check({name, "_one_done"}, 64'(done_cnt), 64'd1);
        check({name, "_error_sticky"}, 64'(error), 64'(m_error));
        $display("load %s base=%08h n=%0d lat=%0d error=%0d words=%0d", name, base, n, lat, error, words_written);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, req0, n;
        logic [31:0] b;
        #23;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_words", 64'(words_written), 64'd0);
        check("rst_req", 64'(bus.req), 64'd0);
        check("rst_we", 64'(bus.we), 64'd0);
        check("rst_be", 64'(bus.be), 64'd0);
        check("rst_addr", 64'(bus.addr), 64'd0);
        check("rst_wdata", 64'(bus.wdata), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Four words at 0x00, zero-wait slave, stream always valid: 3 (or 5) cycles per word.
        stream = '{32'h0123_4567, 32'h89AB_CDEF, 32'hDEAD_BEEF, 32'h0BAD_F00D};
        run_load("basic4", 32'h0000_0000, 4, 0, 0, 0, -1, -1, 1'b0, 1'b0, lat);
        check("basic4_latency", 64'(lat), VERIFY ? 64'd21 : 64'd13);
        check("basic4_mem0", 64'(mem[32'h0]), 64'h0123_4567);
        check("basic4_mem4", 64'(mem[32'h4]), 64'h89AB_CDEF);
        check("basic4_mem8", 64'(mem[32'h8]), 64'hDEAD_BEEF);
        check("basic4_memC", 64'(mem[32'hC]), 64'h0BAD_F00D);
        check("basic4_words_lit", 64'(words_written), 64'd4);

        // gnt held low 3 cycles; base low bits must be dropped.
        fill_random(1);
        run_load("gnt_wait", 32'h0000_0103, 1, 3, 0, 0, -1, -1, 1'b0, 1'b0, lat);
        check("gnt_wait_writes", 64'(wr_idx), 64'd1);
        check("gnt_wait_latency", 64'(lat), VERIFY ? 64'd12 : 64'd7);

        fill_random(0);
        req0 = req_cycles;
        run_load("zero_count", 32'h0000_0040, 0, 0, 0, 0, -1, -1, 1'b0, 1'b0, lat);
        check("zero_count_latency", 64'(lat), 64'd1);
        check("zero_count_no_req", 64'(req_cycles - req0), 64'd0);

        fill_random(5);
        run_load("err_word2", 32'h0000_0200, 5, -1, 2, 2, 1, -1, 1'b1, 1'b0, lat);
        check("err_word2_error", 64'(error), 64'd1);
        check("err_word2_words", 64'(words_written), 64'd1);
        check("err_word2_writes", 64'(wr_idx), 64'd2);

        fill_random(3);
        run_load("corrupt0", 32'h0000_0300, 3, 0, 0, 0, -1, 0, 1'b0, 1'b0, lat);
        check("corrupt0_error", 64'(error), VERIFY ? 64'd1 : 64'd0);
        check("corrupt0_words", 64'(words_written), VERIFY ? 64'd1 : 64'd3);
        check("corrupt0_reads", 64'(rd_idx), VERIFY ? 64'd1 : 64'd0);

        // Reset while a write is waiting for gnt.
        fill_random(2);
        @(negedge clk);
        gnt_fixed = 6; err_at = -1; corrupt_at = -1; valid_rand = 1'b0;
        model_load(32'h0000_0400, 2);
        src_idx = 0; wr_idx = 0; rd_idx = 0;
        start = 1'b1; base_addr = 32'h0000_0400; word_count = CNT_W'(2);
        @(posedge clk); #2;
        start = 1'b0;
        for (int k = 0; k < 20 && !bus.req; k++) begin
            @(posedge clk); #2;
        end
        check("rstmid_req_seen", 64'(bus.req), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rstmid_req", 64'(bus.req), 64'd0);
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_in_ready", 64'(in_ready), 64'd0);
        check("rstmid_addr", 64'(bus.addr), 64'd0);
        check("rstmid_words", 64'(words_written), 64'd0);
        @(negedge clk); exp_q.delete();
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
        fill_random(3);
        run_load("after_rst", 32'h0000_0400, 3, -1, 2, 2, -1, -1, 1'b1, 1'b0, lat);

        for (int i = 0; i < 25; i++) begin
            bit poke;
            int e_at, c_at;
            poke = (i % 5 == 2);
            n = poke ? $urandom_range(3, 8) : $urandom_range(1, 8);
            b = (i % 4 == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            e_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
            c_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
            fill_random(n);
            run_load($sformatf("rand%0d", i), b, n, -1, 3, 3, e_at, c_at, 1'b1, poke, lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
